// File: rtl/pedal_chain_sequencer.sv
// Walks one sample through NUM_STAGES effect slots via START/DONE handshakes.
// Optional slot timeout is enabled by defining PEDAL_CHAIN_TIMEOUT_EN.
module pedal_chain_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NUM_STAGES  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic [DATA_W-1:0]            Sample_in,
    input  logic                         Sample_valid,
    input  logic [NUM_STAGES-1:0]        Bypass,
    input  logic                         Clear,
    output logic [DATA_W-1:0]            Stage_in,
    output logic [NUM_STAGES-1:0]        Stage_start,
    input  logic [NUM_STAGES-1:0]        Stage_done,
    input  logic [NUM_STAGES*DATA_W-1:0] Stage_out,
    output logic [DATA_W-1:0]            Signal_out,
    output logic                         Signal_valid,
    output logic                         Busy,
    output logic                         Overrun,
    output logic                         Timeout_err
);

    localparam int IW = $clog2(NUM_STAGES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_EMIT  = 2'd3;

    if (NUM_STAGES < 1 || NUM_STAGES > 16 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("pedal_chain_sequencer: parameter out of range");
    end

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_W-1:0]     work_q, work_d;
    logic [NUM_STAGES-1:0] start_q, start_d;
    logic [DATA_W-1:0]     sig_out_q, sig_out_d;
    logic                  sig_vld_q, sig_vld_d;
    logic                  overrun_q, overrun_d;

    logic                  last_slot;
    logic                  cur_bypass;
    logic                  cur_done;
    logic [DATA_W-1:0]     cur_out;
    logic                  ovr_set;

`ifdef PEDAL_CHAIN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          tmo_set;
`endif

    // Only the slot addressed by idx is looked at; other DONE bits are ignored.
    always_comb begin
        last_slot  = (idx_q == IW'(NUM_STAGES));
        cur_bypass = 1'b0;
        cur_done   = 1'b0;
        cur_out    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IW'(i)) begin
                cur_bypass = Bypass[i];
                cur_done   = Stage_done[i];
                cur_out    = Stage_out[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        work_d    = work_q;
        start_d   = '0;
        sig_out_d = sig_out_q;
        sig_vld_d = 1'b0;
`ifdef PEDAL_CHAIN_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_set   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (Sample_valid) begin
                    work_d  = Sample_in;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_slot) begin
                    sig_out_d = work_q;
                    sig_vld_d = 1'b1;
                    state_d   = S_EMIT;
                end else if (cur_bypass) begin
                    idx_d = idx_q + IW'(1);
                end else begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        start_d[i] = (idx_q == IW'(i));
                    end
`ifdef PEDAL_CHAIN_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cur_done) begin
                    work_d  = cur_out;
                    idx_d   = idx_q + IW'(1);
                    state_d = S_ISSUE;
`ifdef PEDAL_CHAIN_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    // Stuck slot is skipped: work keeps the previous slot's result.
                    tmo_set = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            S_EMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A set event in the same cycle as Clear keeps the flag up.
        ovr_set   = Sample_valid && (state_q != S_IDLE);
        overrun_d = ovr_set ? 1'b1 : (Clear ? 1'b0 : overrun_q);
`ifdef PEDAL_CHAIN_TIMEOUT_EN
        tmo_d     = tmo_set ? 1'b1 : (Clear ? 1'b0 : tmo_q);
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            work_q    <= '0;
            start_q   <= '0;
            sig_out_q <= '0;
            sig_vld_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            work_q    <= work_d;
            start_q   <= start_d;
            sig_out_q <= sig_out_d;
            sig_vld_q <= sig_vld_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef PEDAL_CHAIN_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign Timeout_err = tmo_q;
`else
    assign Timeout_err = 1'b0;
`endif

    assign Stage_in     = work_q;
    assign Stage_start  = start_q;
    assign Signal_out   = sig_out_q;
    assign Signal_valid = sig_vld_q;
    assign Busy         = (state_q != S_IDLE);
    assign Overrun      = overrun_q;

endmodule

// File: tb/tb_pedal_chain_sequencer.sv
// Scoreboard bench for pedal_chain_sequencer with behavioural effect slots.
// Slot k returns Stage_in + slot_add[k] after slot_dly[k] cycles (negative = never).
module tb_pedal_chain_sequencer;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int TO = 8;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic [DW-1:0]     Sample_in;
    logic              Sample_valid;
    logic [NS-1:0]     Bypass;
    logic              Clear;
    logic [DW-1:0]     Stage_in;
    logic [NS-1:0]     Stage_start;
    logic [NS-1:0]     Stage_done;
    logic [NS*DW-1:0]  Stage_out;
    logic [DW-1:0]     Signal_out;
    logic              Signal_valid;
    logic              Busy;
    logic              Overrun;
    logic              Timeout_err;

    pedal_chain_sequencer #(.DATA_W(DW), .NUM_STAGES(NS), .TIMEOUT_CYC(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Sample_in(Sample_in), .Sample_valid(Sample_valid),
        .Bypass(Bypass), .Clear(Clear), .Stage_in(Stage_in), .Stage_start(Stage_start),
        .Stage_done(Stage_done), .Stage_out(Stage_out), .Signal_out(Signal_out),
        .Signal_valid(Signal_valid), .Busy(Busy), .Overrun(Overrun), .Timeout_err(Timeout_err)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [DW-1:0] exp_q[$];
    int            lat_q[$];
    logic [DW-1:0] obs_q[$];
    int            obs_cyc_q[$];
    logic [NS-1:0] start_log[$];

    logic [DW-1:0] slot_add [NS];
    int            slot_dly [NS];
    int            mcnt     [NS];
    logic [NS-1:0] mdl_done = '0;
    logic [NS-1:0] force_done = '0;
    logic [NS*DW-1:0] mdl_out = '0;

    assign Stage_done = mdl_done | force_done;
    assign Stage_out  = mdl_out;

    always @(posedge Clk) cyc <= cyc + 1;

    // Slot model and output monitor, both evaluated away from the active edge.
    always @(negedge Clk) begin
        for (int i = 0; i < NS; i++) begin
            mdl_done[i] = 1'b0;
            if (Stage_start[i]) begin
                mdl_out[i*DW +: DW] = Stage_in + slot_add[i];
                if (slot_dly[i] == 0) mdl_done[i] = 1'b1;
                else mcnt[i] = slot_dly[i];
            end else if (mcnt[i] > 0) begin
                mcnt[i] = mcnt[i] - 1;
                if (mcnt[i] == 0) mdl_done[i] = 1'b1;
            end
        end
        if (Signal_valid) begin
            obs_q.push_back(Signal_out);
            obs_cyc_q.push_back(cyc);
        end
        if (Stage_start != '0) start_log.push_back(Stage_start);
    end

    task automatic send(input logic [DW-1:0] d);
        @(negedge Clk);
        Sample_in    = d;
        Sample_valid = 1'b1;
        @(negedge Clk);
        Sample_valid = 1'b0;
        acc_cyc      = cyc;
    endtask

    task automatic collect(input int budget, output bit ok, output logic [DW-1:0] got, output int lat);
        ok = 1'b0; got = '0; lat = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            if (obs_q.size() > 0) ok = 1'b1;
            else begin
                @(negedge Clk);
                #1;
            end
        end
        if (!ok && obs_q.size() > 0) ok = 1'b1;
        if (ok) begin
            got = obs_q.pop_front();
            lat = obs_cyc_q.pop_front() - acc_cyc;
        end
    endtask

    task automatic wait_start(input logic [NS-1:0] pat, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge Clk);
            #1;
            if (Stage_start == pat) ok = 1'b1;
        end
    endtask

    function automatic void model(input logic [DW-1:0] s, input logic [NS-1:0] b);
        logic [DW-1:0] x;
        int l;
        x = s;
        l = 1;
        for (int i = 0; i < NS; i++) begin
            if (b[i]) l += 1;
            else begin
                x = x + slot_add[i];
                l += slot_dly[i] + 2;
            end
        end
        exp_q.push_back(x);
        lat_q.push_back(l);
    endfunction

    task automatic score(input string name, input int budget);
        bit ok;
        logic [DW-1:0] got, e;
        int lat, el;
        collect(budget, ok, got, lat);
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no Signal_valid within %0d cycles, required out=%h", name, budget, e);
        end else begin
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s out: got %h required %h", name, got, e);
            end
            checks++;
            if (lat !== el) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, lat, el);
            end
        end
    endtask

    task automatic set_slots(input int d0, input int d1, input int d2, input int d3);
        slot_dly[0] = d0; slot_dly[1] = d1; slot_dly[2] = d2; slot_dly[3] = d3;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; Sample_valid = 1'b0; Sample_in = '0; Bypass = '0; Clear = 1'b0;
        for (int i = 0; i < NS; i++) begin slot_add[i] = 16'd1; mcnt[i] = 0; end
        set_slots(0, 0, 0, 0);
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if ({Busy, Stage_start, Signal_valid, Signal_out, Overrun, Timeout_err, Stage_in} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b start=%b vld=%b out=%h ovr=%b tmo=%b in=%h required all 0",
                     Busy, Stage_start, Signal_valid, Signal_out, Overrun, Timeout_err, Stage_in);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_all_bypass;
        Bypass = 4'b1111;
        start_log.delete();
        model(16'h1234, Bypass);
        send(16'h1234);
        #1;
        checks++;
        if (Busy !== 1'b1) begin errors++; $display("FAIL bypass_busy: got %b required 1", Busy); end
        repeat (4) @(negedge Clk);
        #1;
        checks++;
        if (Signal_valid !== 1'b0) begin errors++; $display("FAIL bypass_early_valid: got %b required 0 after edge 4", Signal_valid); end
        score("all_bypass", 10);
        checks++;
        if (start_log.size() !== 0) begin errors++; $display("FAIL bypass_no_start: got %0d pulses required 0", start_log.size()); end
        repeat (4) @(negedge Clk);
        #1;
        checks++;
        if ({Signal_valid, Busy, Signal_out} !== {1'b0, 1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL bypass_hold: vld=%b busy=%b out=%h required 0 0 1234", Signal_valid, Busy, Signal_out);
        end
    endtask

    task automatic test_chain;
        Bypass = 4'b0000;
        set_slots(2, 2, 2, 2);
        start_log.delete();
        model(16'h0010, Bypass);
        send(16'h0010);
        score("chain", 60);
        checks++;
        if (start_log.size() !== 4 || start_log[0] !== 4'b0001 || start_log[1] !== 4'b0010 ||
            start_log[2] !== 4'b0100 || start_log[3] !== 4'b1000) begin
            errors++;
            $display("FAIL chain_start_order: got %0d pulses first=%b required 0001,0010,0100,1000",
                     start_log.size(), (start_log.size() > 0) ? start_log[0] : 4'b0000);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] s;
        bit ok;
        slot_add[0] = 16'd1; slot_add[1] = 16'd2; slot_add[2] = 16'd4; slot_add[3] = 16'd8;
        // Fixed corners first (wrap through zero and through the sign bit), then random.
        for (int n = 0; n < 8; n++) begin
            if (n == 0) begin s = 16'hFFFE; Bypass = 4'b1010; set_slots(0, 0, 0, 0); end
            else if (n == 1) begin s = 16'h7FFF; Bypass = 4'b0001; set_slots(0, 1, 3, 0); end
            else begin
                s = 16'($urandom);
                Bypass = 4'($urandom_range(0, 15));
                set_slots($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            model(s, Bypass);
            send(s);
            score("back_to_back", 40);
        end
        #1;
        checks++;
        if (Overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b required 0", Overrun); end
        ok = 1'b1;
    endtask

    task automatic test_overrun;
        bit ok;
        for (int i = 0; i < NS; i++) slot_add[i] = 16'd1;
        Bypass = 4'b0000;
        set_slots(3, 3, 3, 3);
        model(16'h0020, Bypass);
        send(16'h0020);
        wait_start(4'b0010, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overrun_wait_slot1: no START on slot 1 required one"); end
        Sample_in = 16'hDEAD;
        Sample_valid = 1'b1;
        @(negedge Clk);
        Sample_valid = 1'b0;
        #1;
        checks++;
        if (Overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b required 1", Overrun); end
        score("overrun_inflight", 60);
        checks++;
        if (Overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b required 1", Overrun); end
        Bypass = 4'b1111;
        model(16'h0040, Bypass);
        send(16'h0040);
        Sample_valid = 1'b1;
        Clear = 1'b1;
        @(negedge Clk);
        Sample_valid = 1'b0;
        Clear = 1'b0;
        #1;
        checks++;
        if (Overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_beats_clear: got %b required 1", Overrun); end
        @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        #1;
        checks++;
        if (Overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b required 0", Overrun); end
        score("overrun_second", 20);
    endtask

    task automatic test_done_other;
        Bypass = 4'b0000;
        set_slots(8, 0, 0, 0);
        force_done = 4'b1000;
        model(16'h0050, Bypass);
        send(16'h0050);
        repeat (5) @(negedge Clk);
        #1;
        checks++;
        if ({Busy, Stage_start, Stage_in} !== {1'b1, 4'b0000, 16'h0050} || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL done_other_ignored: busy=%b start=%b in=%h outputs=%0d required 1 0000 0050 0",
                     Busy, Stage_start, Stage_in, obs_q.size());
        end
        force_done = '0;
        score("done_other", 40);
    endtask

    task automatic test_reset_mid;
        bit ok;
        Bypass = 4'b0000;
        set_slots(4, 4, 4, 4);
        send(16'h0060);
        wait_start(4'b0001, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_mid_wait: no START on slot 0 required one"); end
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({Stage_start, Busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_immediate: start=%b busy=%b required 0000 0", Stage_start, Busy);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (10) @(negedge Clk);
        #1;
        checks++;
        if (obs_q.size() !== 0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abandon: outputs=%0d busy=%b required 0 0", obs_q.size(), Busy);
        end
        Bypass = 4'b0110;
        set_slots(1, 1, 1, 1);
        slot_add[0] = 16'd1; slot_add[3] = 16'd8;
        model(16'h0070, Bypass);
        send(16'h0070);
        score("after_reset", 30);
    endtask

`ifdef PEDAL_CHAIN_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        slot_add[0] = 16'd1; slot_add[1] = 16'd2; slot_add[2] = 16'd4; slot_add[3] = 16'd8;
        Bypass = 4'b1000;
        set_slots(1, 1, -1, 0);
        exp_q.push_back(16'h0033);
        lat_q.push_back(1 + 3 + 3 + (TO + 1) + 1);
        send(16'h0030);
        wait_start(4'b0100, 30, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_wait_slot2: no START on slot 2 required one"); end
        repeat (TO - 1) @(negedge Clk);
        #1;
        checks++;
        if ({Timeout_err, Busy} !== 2'b01) begin
            errors++;
            $display("FAIL timeout_early: tmo=%b busy=%b required 0 1", Timeout_err, Busy);
        end
        @(negedge Clk);
        #1;
        checks++;
        if (Timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b required 1", Timeout_err); end
        score("timeout", 30);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        #1;
        checks++;
        if (Timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b required 0", Timeout_err); end
        set_slots(1, 1, TO - 1, 0);
        model(16'h0030, Bypass);
        send(16'h0030);
        score("timeout_last_done", 40);
        checks++;
        if (Timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_done_wins: got %b required 0", Timeout_err); end
    endtask
`else
    task automatic test_no_timeout;
        Bypass = 4'b0000;
        set_slots(0, 0, -1, 0);
        send(16'h0030);
        repeat (40) @(negedge Clk);
        #1;
        checks++;
        if ({Busy, Timeout_err} !== 2'b10 || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL no_timeout_waits: busy=%b tmo=%b outputs=%0d required 1 0 0", Busy, Timeout_err, obs_q.size());
        end
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_bypass();
        test_chain();
        test_back_to_back();
        test_overrun();
        test_done_other();
        test_reset_mid();
`ifdef PEDAL_CHAIN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pedal_chain_sequencer.md
PEDAL_CHAIN_SEQUENCER -- requirements
Module: pedal_chain_sequencer

Interface
REQ-001 Parameter DATA_W, 16, sample width in bits (two's complement).
REQ-002 Parameter NUM_STAGES, 4, number of effect slots in the chain (1..16).
REQ-003 Parameter TIMEOUT_CYC, 1024, maximum cycles to wait for a stage DONE (>=2).
REQ-004 Clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Sample_in  input  DATA_W  new dry sample.
REQ-007 Sample_valid  input  1  Sample_in is valid this cycle.
REQ-008 Bypass  input  NUM_STAGES  bit i high = slot i skipped, sampled when the sequencer reaches slot i.
REQ-009 Clear  input  1  synchronous clear of the sticky error flags.
REQ-010 Stage_in  output  DATA_W  working sample presented to all slots, driven from the work register.
REQ-011 Stage_start  output  NUM_STAGES  one-hot START pulse to slot i.
REQ-012 Stage_done  input  NUM_STAGES  DONE from slot i.
REQ-013 Stage_out  input  NUM_STAGES*DATA_W  slot i result at bits [i*DATA_W +: DATA_W].
REQ-014 Signal_out  output  DATA_W  processed sample, registered.
REQ-015 Signal_valid  output  1  one-cycle pulse, Signal_out updated.
REQ-016 Busy  output  1  high in any state other than IDLE.
REQ-017 Overrun  output  1  sticky: a Sample_valid was dropped.
REQ-018 Timeout_err  output  1  sticky: a slot failed to return DONE in time.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, EMIT; register idx (0..NUM_STAGES) SHALL hold the current slot.
REQ-020 IDLE: on Sample_valid, work <= Sample_in, idx <= 0, go to ISSUE; otherwise stay.
REQ-021 ISSUE with idx==NUM_STAGES: Signal_out <= work, Signal_valid <= 1, go to EMIT.
REQ-022 ISSUE with Bypass[idx]==1: idx <= idx+1, stay in ISSUE (one cycle per bypassed slot, work unchanged).
REQ-023 ISSUE with Bypass[idx]==0: Stage_start[idx] <= 1, clear timeout counter, go to WAIT.
REQ-024 Stage_start SHALL be high for exactly the first cycle of WAIT and zero at all other times; at most one bit high.
REQ-025 WAIT: Stage_done[idx]==1 (including the first WAIT cycle) -> work <= Stage_out slice idx, idx <= idx+1, go to ISSUE; Stage_done bits of other slots SHALL be ignored.
REQ-026 EMIT: Signal_valid <= 0, go to IDLE; Signal_out SHALL hold its value until the next EMIT.
REQ-027 Sample_valid in any state other than IDLE SHALL be dropped and set Overrun; IDLE SHALL accept it in the same cycle EMIT is left.
REQ-028 All-bypass latency: Signal_valid SHALL be high after rising edge NUM_STAGES+1 counted from the edge that accepted Sample_valid; each active slot adds (DONE wait cycles + 1).
REQ-029 Clear SHALL zero Overrun and Timeout_err; a simultaneous set event SHALL win over Clear.
REQ-030 No arithmetic is performed on samples; widths SHALL pass through unchanged.

Reset
REQ-031 Reset_n low SHALL immediately force state IDLE, idx 0, work 0, Stage_start 0, Signal_out 0, Signal_valid 0, Overrun 0, Timeout_err 0, counter 0.
REQ-032 Reset mid-WAIT SHALL abandon the sample with no Signal_valid; a late Stage_done after reset SHALL be ignored.

Configuration
REQ-033 With PEDAL_CHAIN_TIMEOUT_EN defined: after TIMEOUT_CYC cycles in WAIT without Stage_done[idx], work SHALL be kept (slot treated as bypassed), Timeout_err set, idx incremented, go to ISSUE; DONE in the final counted cycle SHALL win over timeout.
REQ-034 Without PEDAL_CHAIN_TIMEOUT_EN: no counter SHALL exist, WAIT SHALL wait indefinitely, Timeout_err SHALL be tied 0.

Verification
REQ-035 Bypass=4'b1111, Sample_in=16'h1234 pulsed -> Signal_valid after edge 5, Signal_out=16'h1234, no Stage_start bits set.
REQ-036 Bypass=4'b0000, each slot returns DONE 2 cycles after START with Stage_out = Stage_in+1, Sample_in=16'h0010 -> Signal_out=16'h0014, Stage_start pulses 0001,0010,0100,1000 in order.
REQ-037 Sample_valid pulsed during WAIT of slot 1 -> Overrun=1, in-flight result unaffected; Clear -> Overrun=0.
REQ-038 PEDAL_CHAIN_TIMEOUT_EN, TIMEOUT_CYC=8, slot 2 never DONE -> Timeout_err=1 after 8 WAIT cycles, Signal_out equals slot 1 result.
REQ-039 Reset_n low for 1 cycle while in WAIT -> Stage_start=0 and Busy=0 immediately, no Signal_valid, next sample processed normally.
REQ-040 Stage_done[3] held high while waiting on slot 0 -> ignored, sequencer stays in WAIT.
